// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO read port, the UART drain stage and the TX pin.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic              tx;
  logic              busy;
  logic              byte_done;

  modport master (
    input  fifo_empty, rd_data,
    output rd_en, tx, busy, byte_done
  );

  modport slave (
    output fifo_empty, rd_data,
    input  rd_en, tx, busy, byte_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains sync_fifo one byte at a time and serialises each byte as an 8N1 UART frame.
// state | meaning
// IDLE  | line high, waiting for a non-empty FIFO
// REQ   | one-cycle rd_en pulse
// LOAD  | capture rd_data into the shift register
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); byte_done on its last cycle
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]        r_state;
  logic [BW-1:0]     r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [DATA_W-1:0] r_shift;

  logic [2:0]        w_state_next;
  logic              w_baud_last;
  logic              w_timed;

  assign w_baud_last = (r_baud_cnt == BAUD_LAST);
  assign w_timed     = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!bus.fifo_empty) w_state_next = S_REQ;
      S_REQ:   w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_START;
      S_START: if (w_baud_last) w_state_next = S_DATA;
      S_DATA:  if (w_baud_last && (r_bit_idx == BIT_LAST)) w_state_next = S_STOP;
      S_STOP:  if (w_baud_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Baud counter only runs in the timed states and restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_state_next;

      if (!w_timed || (w_state_next != r_state) || w_baud_last)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + BW'(1);

      if (r_state == S_LOAD) begin
        r_shift   <= bus.rd_data;
        r_bit_idx <= '0;
      end else if ((r_state == S_DATA) && w_baud_last) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= (r_bit_idx == BIT_LAST) ? 3'd0 : r_bit_idx + 3'd1;
      end
    end
  end

  assign bus.rd_en     = (r_state == S_REQ);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.byte_done = (r_state == S_STOP) && w_baud_last;

  always_comb begin
    case (r_state)
      S_START: bus.tx = 1'b0;
      S_DATA:  bus.tx = r_shift[0];
      default: bus.tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (CLKS_PER_BIT 4 and 1) each fed by a queue FIFO model.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_W(8)) b4 ();
  fifo_uart_tx_if #(.DATA_W(8)) b1 ();

  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  fifo_uart_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int total = 0;
  int bad   = 0;
  int uf4   = 0;
  int uf1   = 0;

  logic       push_v4 = 1'b0;
  logic       push_v1 = 1'b0;
  logic [7:0] push_d4 = 8'h00;
  logic [7:0] push_d1 = 8'h00;
  logic [7:0] q4[$];
  logic [7:0] q1[$];

  // Queue-based stand-in for sync_fifo: registered empty flag, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rst) begin
      q4.delete();
      b4.fifo_empty <= 1'b1;
      b4.rd_data    <= 8'h00;
    end else begin
      if (b4.rd_en) begin
        if (q4.size() == 0) uf4++;
        else b4.rd_data <= q4.pop_front();
      end
      if (push_v4) q4.push_back(push_d4);
      b4.fifo_empty <= (q4.size() == 0);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      b1.fifo_empty <= 1'b1;
      b1.rd_data    <= 8'h00;
    end else begin
      if (b1.rd_en) begin
        if (q1.size() == 0) uf1++;
        else b1.rd_data <= q1.pop_front();
      end
      if (push_v1) q1.push_back(push_d1);
      b1.fifo_empty <= (q1.size() == 0);
    end
  end

  function automatic logic g_tx(input bit s);   return s ? b1.tx        : b4.tx;        endfunction
  function automatic logic g_rd(input bit s);   return s ? b1.rd_en     : b4.rd_en;     endfunction
  function automatic logic g_busy(input bit s); return s ? b1.busy      : b4.busy;      endfunction
  function automatic logic g_done(input bit s); return s ? b1.byte_done : b4.byte_done; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit s, input logic [7:0] d);
    if (s) begin push_v1 = 1'b1; push_d1 = d; end
    else   begin push_v4 = 1'b1; push_d4 = d; end
    @(negedge clk);
    push_v1 = 1'b0;
    push_v4 = 1'b0;
  endtask

  task automatic wait_req(input bit s, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!g_rd(s) && n < 200);
    chk("rd_en_seen", 32'(g_rd(s)), 1);
  endtask

  // Entered on the REQ cycle sample; checks LOAD and then the whole 10-bit frame.
  task automatic check_frame(input bit s, input logic [0:9] exp);
    int cpb;
    cpb = s ? 1 : 4;
    chk("req_tx", 32'(g_tx(s)), 1);
    chk("req_busy", 32'(g_busy(s)), 1);
    @(negedge clk);
    chk("load_rd_en", 32'(g_rd(s)), 0);
    chk("load_tx", 32'(g_tx(s)), 1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        chk($sformatf("tx s%0d b%0d c%0d", s, b, c), 32'(g_tx(s)), 32'(exp[b]));
        chk($sformatf("byte_done s%0d b%0d c%0d", s, b, c), 32'(g_done(s)),
            32'((b == 9) && (c == cpb - 1)));
        chk("frame_rd_en", 32'(g_rd(s)), 0);
        chk("frame_busy", 32'(g_busy(s)), 1);
      end
    end
  endtask

  typedef logic [7:0] byte4_t [4];
  typedef logic [0:9] frm4_t  [4];

  task automatic burst(input bit s, input int cnt, input byte4_t d, input frm4_t e);
    int n;
    fork
      begin
        for (int i = 0; i < cnt; i++) push(s, d[i]);
      end
      begin
        for (int i = 0; i < cnt; i++) begin
          wait_req(s, n);
          if (i > 0) chk("b2b_gap", 32'(n), 2);
          check_frame(s, e[i]);
        end
      end
    join
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("burst_end_busy", 32'(g_busy(s)), 0);
      chk("burst_end_rd_en", 32'(g_rd(s)), 0);
      chk("burst_end_tx", 32'(g_tx(s)), 1);
    end
  endtask

  typedef struct {
    bit         s;
    logic [7:0] data;
    logic [0:9] frame;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    logic [0:9] fa5;

    vecs[0] = '{1'b0, 8'h05, 10'b0101000001};
    vecs[1] = '{1'b0, 8'h3C, 10'b0001111001};
    vecs[2] = '{1'b0, 8'hFF, 10'b0111111111};
    vecs[3] = '{1'b0, 8'h00, 10'b0000000001};
    vecs[4] = '{1'b1, 8'hFF, 10'b0111111111};
    vecs[5] = '{1'b1, 8'h00, 10'b0000000001};
    vecs[6] = '{1'b1, 8'h5A, 10'b0010110101};

    // Reset hold, then 50 idle cycles with an empty FIFO.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_tx", 32'(g_tx(s[0])), 1);
      chk("rst_rd_en", 32'(g_rd(s[0])), 0);
      chk("rst_busy", 32'(g_busy(s[0])), 0);
      chk("rst_done", 32'(g_done(s[0])), 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("idle_tx", 32'(g_tx(s[0])), 1);
        chk("idle_rd_en", 32'(g_rd(s[0])), 0);
        chk("idle_busy", 32'(g_busy(s[0])), 0);
      end
    end

    // Single bytes from the vector table.
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].s, vecs[i].data);
      wait_req(vecs[i].s, n);
      chk("req_latency", 32'(n), 1);
      check_frame(vecs[i].s, vecs[i].frame);
      @(negedge clk);
      chk("post_busy", 32'(g_busy(vecs[i].s)), 0);
      chk("post_tx", 32'(g_tx(vecs[i].s)), 1);
      repeat (3) @(negedge clk);
    end

    // Four back-to-back bytes at CLKS_PER_BIT=4.
    burst(1'b0, 4, '{8'h05, 8'h0A, 8'h14, 8'h1E},
          '{10'b0101000001, 10'b0010100001, 10'b0001010001, 10'b0011110001});

    // Back-to-back 0xFF, 0x00 at CLKS_PER_BIT=1.
    burst(1'b1, 2, '{8'hFF, 8'h00, 8'h00, 8'h00},
          '{10'b0111111111, 10'b0000000001, 10'b0000000001, 10'b0000000001});

    // Reset during DATA bit 3 of 0xA5; the queued 0x3C is discarded with the FIFO.
    fa5 = 10'b0101001011;
    fork
      begin
        push(1'b0, 8'hA5);
        push(1'b0, 8'h3C);
      end
      begin
        wait_req(1'b0, n);
        @(negedge clk);
        for (int k = 0; k < 18; k++) begin
          @(negedge clk);
          chk($sformatf("a5_tx k%0d", k), 32'(g_tx(1'b0)), 32'(fa5[k / 4]));
        end
      end
    join
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", 32'(g_tx(1'b0)), 1);
    chk("midrst_busy", 32'(g_busy(1'b0)), 0);
    chk("midrst_rd_en", 32'(g_rd(1'b0)), 0);
    chk("midrst_done", 32'(g_done(1'b0)), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("midrst_hold_rd_en", 32'(g_rd(1'b0)), 0);
      chk("midrst_hold_tx", 32'(g_tx(1'b0)), 1);
    end
    push(1'b0, 8'h3C);
    wait_req(1'b0, n);
    chk("refill_latency", 32'(n), 1);
    check_frame(1'b0, 10'b0001111001);
    repeat (3) @(negedge clk);

    // Reset landing on the REQ cycle cancels the pop.
    push(1'b0, 8'h66);
    wait_req(1'b0, n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reqrst_tx", 32'(g_tx(1'b0)), 1);
    chk("reqrst_busy", 32'(g_busy(1'b0)), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("reqrst_rd_en", 32'(g_rd(1'b0)), 0);
      chk("reqrst_busy_hold", 32'(g_busy(1'b0)), 0);
    end

    // FIFO written mid-frame: second pop only after byte_done.
    fork
      begin
        push(1'b0, 8'h05);
        repeat (12) @(negedge clk);
        push(1'b0, 8'h3C);
      end
      begin
        wait_req(1'b0, n);
        check_frame(1'b0, 10'b0101000001);
        wait_req(1'b0, n);
        chk("midwrite_gap", 32'(n), 2);
        check_frame(1'b0, 10'b0001111001);
      end
    join
    @(negedge clk);
    chk("midwrite_end_busy", 32'(g_busy(1'b0)), 0);

    chk("no_underflow", 32'(uf4 + uf1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
